// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: one 4-bit slice iterated NIB times with a registered
// inter-nibble carry, wrapped in valid/ready handshakes on both sides.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | InReady high; operands and Cin captured on InValid
// RUN   | one nibble per cycle through the slice, LSB nibble first
// DONE  | OutValid high, Sum held until OutReady
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH:0]   Sum
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   sum_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic [4:0]       slice;

    // Full 5-bit add so the nibble carry is the true carry, not a top-bit generate.
    assign slice = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0000, carry};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            carry <= 1'b0;
            count <= '0;
            sum_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        a_r   <= A;
                        b_r   <= B;
                        carry <= Cin;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[WIDTH-1:0] <= {slice[3:0], sum_r[WIDTH-1:4]};
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    carry <= slice[4];
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        sum_r[WIDTH] <= slice[4];
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign Sum      = sum_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: transaction-level reference
// model checked every cycle, plus directed cases with literal results.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [W:0]   Sum;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Cin(Cin), .OutValid(OutValid), .OutReady(OutReady),
        .Sum(Sum)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: an accepted operation becomes A+B+Cin, which is
    // presented NIB+1 edges after acceptance and held until OutReady.
    int         m_phase = 0;     // 0 waiting for operands, 1 computing, 2 presenting
    int         m_rem = 0;
    logic [W:0] m_exp = '0;
    bit         m_zero = 1'b1;   // Sum known to be the reset value
    int         cyc = 0;
    int         acc_times[$];

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            m_phase = 0;
            m_zero  = 1'b1;
        end else begin
            case (m_phase)
                0: if (InValid) begin
                    m_exp   = {1'b0, A} + {1'b0, B} + (W+1)'(Cin);
                    m_rem   = NIB;
                    m_phase = 1;
                    m_zero  = 1'b0;
                    acc_times.push_back(cyc);
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                default: if (OutReady) m_phase = 0;
            endcase
        end
    end

    bit         chk_en = 1'b0;
    logic [W:0] got_q[$];

    always @(negedge CLK) begin
        if (chk_en) begin
            check("InReady", (W+1)'(InReady), (W+1)'(m_phase == 0));
            check("OutValid", (W+1)'(OutValid), (W+1)'(m_phase == 2));
            if (m_phase == 2) check("Sum", Sum, m_exp);
            else if (m_zero) check("Sum_reset", Sum, '0);
            if (OutValid && OutReady) got_q.push_back(Sum);
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (OutValid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("timeout_OutValid", 0, 1);
    endtask

    // One transaction: present operands for one edge, scramble them, then
    // optionally apply backpressure (with a stray InValid) before OutReady.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W:0] lit, input int hold);
        bit ok;
        @(negedge CLK);
        InValid = 1'b1; A = a; B = b; Cin = c; OutReady = 1'b0;
        @(negedge CLK);
        InValid = 1'b0; A = $urandom; B = $urandom; Cin = $urandom_range(0, 1);
        wait_valid(ok);
        if (ok) begin
            check("literal_sum", Sum, lit);
            for (int i = 0; i < hold; i++) begin
                InValid = 1'b1; A = $urandom; B = $urandom;
                @(negedge CLK);
                check("bp_hold_sum", Sum, lit);
                check("bp_inready", (W+1)'(InReady), 0);
            end
            InValid  = 1'b0;
            OutReady = 1'b1;
            @(negedge CLK);
            OutReady = 1'b0;
            check("idle_after_ready", (W+1)'(InReady), 1);
        end
    endtask

    initial begin
        bit ok;
        int seen;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk_en = 1'b1;
        check("reset_inready", (W+1)'(InReady), 1);
        check("reset_outvalid", (W+1)'(OutValid), 0);
        check("reset_sum", Sum, '0);

        run_op(16'h1234, 16'h4321, 1'b1, 17'h05556, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 17'h05556, 10);

        // Reset during the second RUN cycle discards the operation.
        @(negedge CLK);
        InValid = 1'b1; A = 16'hABCD; B = 16'h1111; Cin = 1'b0;
        @(negedge CLK);
        InValid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_inready", (W+1)'(InReady), 1);
        check("rst_mid_outvalid", (W+1)'(OutValid), 0);
        check("rst_mid_sum", Sum, '0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (OutValid) seen++;
        end
        check("rst_no_result", (W+1)'(seen), 0);
        run_op(16'h0001, 16'h0001, 1'b0, 17'h00002, 0);

        // Back-to-back with InValid and OutReady held high.
        acc_times.delete();
        got_q.delete();
        @(negedge CLK);
        InValid = 1'b1; OutReady = 1'b1; A = 16'h1234; B = 16'h4321; Cin = 1'b1;
        @(negedge CLK);
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
        for (int i = 0; i < 20 && acc_times.size() < 2; i++) @(negedge CLK);
        InValid = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge CLK);
        OutReady = 1'b0;
        check("b2b_accepts", (W+1)'(acc_times.size()), 2);
        if (acc_times.size() >= 2)
            check("b2b_spacing", (W+1)'(acc_times[1] - acc_times[0]), (W+1)'(NIB + 2));
        check("b2b_results", (W+1)'(got_q.size()), 2);
        if (got_q.size() >= 2) begin
            check("b2b_first", got_q[0], 17'h05556);
            check("b2b_second", got_q[1], 17'h1FFFF);
        end

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            A   = $urandom;
            B   = $urandom;
            Cin = $urandom_range(0, 1);
            RST = ($urandom_range(0, 99) == 0);
        end
        @(negedge CLK);
        RST = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        repeat (12) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
